// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared mode codes and widths for the LED pattern path
// Purpose: constants shared by led_mode_ctrl and the downstream pattern generator.
// Contents: mode codes, speed width, and the mode-advance helper.
package led_pkg;

  localparam logic [1:0] MODE_BOUNCE = 2'b00;
  localparam logic [1:0] MODE_WIDE   = 2'b01;
  localparam logic [1:0] MODE_LFSR   = 2'b10;
  localparam logic [1:0] MODE_OFF    = 2'b11;

  localparam int SPEED_W = 2;

  typedef logic [SPEED_W-1:0] speed_t;

  // MODE_OFF is never produced by the sequence; if it is ever seen,
  // the next press recovers to MODE_BOUNCE.
  function automatic logic [1:0] next_mode(input logic [1:0] cur);
    case (cur)
      MODE_BOUNCE: next_mode = MODE_WIDE;
      MODE_WIDE:   next_mode = MODE_LFSR;
      default:     next_mode = MODE_BOUNCE;
    endcase
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - two-flop synchroniser, debouncer and press detector
// Purpose: turns one raw asynchronous button into a clean level and a press pulse.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   raw          raw button input, high = pressed
//   stable       debounced button level
//   press_pulse  one-cycle pulse on each rising edge of stable
module btn_debounce
  import led_pkg::*;
#(
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic stable,
  output logic press_pulse
);

  localparam int CNT_W = $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;

  always_comb begin
    sync1_d  = raw;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = '0;
    // The counter only runs while the synchronised input disagrees with the
    // accepted level; any return to agreement restarts the qualification.
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    // Registered so the pulse lines up with the new stable level.
    press_d = stable_d & ~stable_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      press_q  <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      press_q  <= press_d;
    end
  end

  assign stable      = stable_q;
  assign press_pulse = press_q;

endmodule

// File: rtl/led_mode_ctrl.sv
// rtl/led_mode_ctrl.sv - button front end: mode/speed registers and step tick divider
// Purpose: debounces the mode and speed buttons, cycles mode and speed level,
//   and emits a one-cycle step_tick every (TICK_BASE >> speed) cycles.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   btn_mode, btn_speed  raw buttons, high = pressed
//   mode                 pattern select (MODE_BOUNCE / MODE_WIDE / MODE_LFSR)
//   speed                speed level 0..3
//   step_tick            one-cycle enable for the pattern step
module led_mode_ctrl
  import led_pkg::*;
#(
  parameter int DB_CYCLES = 1_000_000,
  parameter int TICK_BASE = 12_500_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_mode,
  input  logic               btn_speed,
  output logic [1:0]         mode,
  output logic [SPEED_W-1:0] speed,
  output logic               step_tick
);

  localparam int TICK_W = $clog2(TICK_BASE);

  logic              mode_press, speed_press;
  logic [1:0]        held_unused;

  logic [1:0]        mode_q, mode_d;
  speed_t            speed_q, speed_d;
  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [TICK_W-1:0] tick_last;
  logic              step_tick_q, step_tick_d;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_mode (
    .clk         (clk),
    .rst         (rst),
    .raw         (btn_mode),
    .stable      (held_unused[0]),
    .press_pulse (mode_press)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_speed (
    .clk         (clk),
    .rst         (rst),
    .raw         (btn_speed),
    .stable      (held_unused[1]),
    .press_pulse (speed_press)
  );

  always_comb begin
    mode_d      = mode_q;
    speed_d     = speed_q;
    tick_last   = TICK_W'((TICK_BASE >> speed_q) - 1);
    tick_cnt_d  = '0;
    step_tick_d = 1'b0;

    if (mode_press) begin
      mode_d = next_mode(mode_q);
    end
    if (speed_press) begin
      speed_d = speed_q + 1'b1;
    end

    // A speed change restarts the period so the next tick is a full new
    // period away; mode changes leave the divider alone.
    if (!speed_press) begin
      if (tick_cnt_q < tick_last) begin
        tick_cnt_d = tick_cnt_q + 1'b1;
      end
      // Registered strobe: high exactly while the counter sits at P-1.
      step_tick_d = (tick_cnt_d == tick_last);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q      <= MODE_BOUNCE;
      speed_q     <= '0;
      tick_cnt_q  <= '0;
      step_tick_q <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      speed_q     <= speed_d;
      tick_cnt_q  <= tick_cnt_d;
      step_tick_q <= step_tick_d;
    end
  end

  assign mode      = mode_q;
  assign speed     = speed_q;
  assign step_tick = step_tick_q;

endmodule
